// File: rtl/opfetch_pkg.sv
// Shared types and sizes for the operand fetch / issue stage.
// Build option: OPFETCH_BYPASS_EN enables same-cycle writeback bypass.
package opfetch_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

  // Address match that never fires for x0.
  function automatic logic reg_hit(
    input logic                  en,
    input logic [REG_ADDR_W-1:0] a,
    input logic [REG_ADDR_W-1:0] b
  );
    return en && (a == b) && (a != '0);
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard: one bit per register, x0 never pending.
// Set and clear on the same register in one cycle resolves to set.
module opfetch_scoreboard
  import opfetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  pend1,
  output logic                  pend2
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_rd] = 1'b0;
    if (set_en) pending_nxt[set_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign pend1 = pending[rs1];
  assign pend2 = pending[rs2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch and issue stage between decode and execute.
// Build option: OPFETCH_BYPASS_EN enables same-cycle writeback bypass.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int PAYLOAD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  output logic [REG_ADDR_W-1:0] rf_r1,
  output logic [REG_ADDR_W-1:0] rf_r2,
  output logic                  rf_r_en,
  input  logic [XLEN-1:0]       rf_r1_read,
  input  logic [XLEN-1:0]       rf_r2_read,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_op1,
  output logic [XLEN-1:0]       out_op2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_wen,
  output logic [PAYLOAD_W-1:0]  out_payload
);

  state_e                state;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic                  hs;
  logic                  accept;
  logic                  pend1;
  logic                  pend2;
  logic                  fwd1;
  logic                  fwd2;
  logic                  wb_hit1;
  logic                  wb_hit2;
  logic                  haz1;
  logic                  haz2;

  assign out_valid = (state == VALID);
  assign hs        = out_valid & out_ready;

  opfetch_scoreboard u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (hs & out_rd_wen),
    .set_rd (out_rd),
    .clr_en (wb_valid),
    .clr_rd (wb_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .pend1  (pend1),
    .pend2  (pend2)
  );

  // The instruction leaving this cycle is not in the scoreboard yet.
  assign fwd1    = reg_hit(hs & out_rd_wen, in_rs1, out_rd);
  assign fwd2    = reg_hit(hs & out_rd_wen, in_rs2, out_rd);
  assign wb_hit1 = reg_hit(wb_valid, in_rs1, wb_rd);
  assign wb_hit2 = reg_hit(wb_valid, in_rs2, wb_rd);

`ifdef OPFETCH_BYPASS_EN
  assign haz1 = (in_rs1 != '0) & ((pend1 & ~wb_hit1) | fwd1);
  assign haz2 = (in_rs2 != '0) & ((pend2 & ~wb_hit2) | fwd2);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_data, wb_hit1, wb_hit2};
  assign haz1 = (in_rs1 != '0) & (pend1 | fwd1);
  assign haz2 = (in_rs2 != '0) & (pend2 | fwd2);
`endif

  assign in_ready = ~haz1 & ~haz2 & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign rf_r1    = in_rs1;
  assign rf_r2    = in_rs2;
  assign rf_r_en  = accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_payload <= '0;
    end else if (accept) begin
      state       <= VALID;
      rs1_q       <= in_rs1;
      rs2_q       <= in_rs2;
      out_rd      <= in_rd;
      out_rd_wen  <= in_rd_wen;
      out_payload <= in_payload;
    end else if (hs) begin
      state <= IDLE;
    end
  end

`ifdef OPFETCH_BYPASS_EN
  logic            byp1;
  logic            byp2;
  logic [XLEN-1:0] byp1_data;
  logic [XLEN-1:0] byp2_data;

  // Capture writeback data now; the register file read returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp1      <= 1'b0;
      byp2      <= 1'b0;
      byp1_data <= '0;
      byp2_data <= '0;
    end else if (accept) begin
      byp1      <= wb_hit1;
      byp2      <= wb_hit2;
      byp1_data <= wb_data;
      byp2_data <= wb_data;
    end
  end
`endif

  always_comb begin
    out_op1 = rf_r1_read;
    out_op2 = rf_r2_read;
`ifdef OPFETCH_BYPASS_EN
    if (byp1) out_op1 = byp1_data;
    if (byp2) out_op2 = byp2_data;
`endif
    if (rs1_q == '0) out_op1 = '0;
    if (rs2_q == '0) out_op2 = '0;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a registered-read register file.
// Expected stall length follows OPFETCH_BYPASS_EN.
module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
  localparam int STALL = 0;
`else
  localparam int STALL = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [31:0] in_payload;
  logic [4:0]  rf_r1;
  logic [4:0]  rf_r2;
  logic        rf_r_en;
  logic [31:0] rf_r1_read;
  logic [31:0] rf_r2_read;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_payload;

  logic [31:0] rf [32];
  int checks;
  int errors;
  int n;

  operand_fetch #(.PAYLOAD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_rd_wen   (in_rd_wen),
    .in_payload  (in_payload),
    .rf_r1       (rf_r1),
    .rf_r2       (rf_r2),
    .rf_r_en     (rf_r_en),
    .rf_r1_read  (rf_r1_read),
    .rf_r2_read  (rf_r2_read),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_rd      (out_rd),
    .out_rd_wen  (out_rd_wen),
    .out_payload (out_payload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
    if (rf_r_en) begin
      rf_r1_read <= rf[rf_r1];
      rf_r2_read <= rf[rf_r2];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen, input logic [31:0] pl);
    in_valid   = v;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_rd_wen  = wen;
    in_payload = pl;
  endtask

  // Waits (bounded) until the presented instruction can be accepted.
  task automatic wait_accept(output int cyc);
    cyc = 0;
    #1;
    while (!in_ready && cyc < 4) begin
      @(negedge clk);
      wb_valid = 1'b0;
      cyc++;
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
    rf[0] = 32'd0;
    rf[5] = 32'd1;
    rf[7] = 32'd2;
    rf_r1_read = '0;
    rf_r2_read = '0;
    rst = 1'b1;
    out_ready = 1'b0;
    wb_valid = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);

    repeat (2) @(negedge clk);
    check("rst_vld", 32'(out_valid), 0);
    check("rst_op1", out_op1, 0);
    check("rst_rd", 32'(out_rd), 0);
    check("rst_wen", 32'(out_rd_wen), 0);
    check("rst_pl", out_payload, 0);
    rst = 1'b0;
    #1;
    check("rst_rdy", 32'(in_ready), 1);
    check("rst_ren", 32'(rf_r_en), 0);

    // back-to-back independent
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd5, 5'd7, 5'(10 + i), 1'b0, 32'hA0 + 32'(i));
      #1;
      check("b2b_rdy", 32'(in_ready), 1);
      check("b2b_ren", 32'(rf_r_en), 1);
      @(negedge clk);
      check("b2b_vld", 32'(out_valid), 1);
      check("b2b_op1", out_op1, 1);
      check("b2b_op2", out_op2, 2);
      check("b2b_pl", out_payload, 32'hA0 + 32'(i));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(out_valid), 0);

    // RAW stall on x3
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'hB0);
    #1;
    check("raw_a_rdy", 32'(in_ready), 1);
    @(negedge clk);
    drive(1'b1, 5'd3, 5'd0, 5'd8, 1'b0, 32'hB1);
    #1;
    check("raw_same", 32'(in_ready), 0);
    @(negedge clk);
    #1;
    check("raw_stall", 32'(in_ready), 0);
    wb_valid = 1'b1;
    wb_rd = 5'd3;
    wb_data = 32'hDEADBEEF;
    wait_accept(n);
    check("raw_lat", 32'(n), 32'(STALL));
    @(negedge clk);
    wb_valid = 1'b0;
    in_valid = 1'b0;
    check("raw_vld", 32'(out_valid), 1);
    check("raw_op1", out_op1, 32'hDEADBEEF);
    check("raw_rd", 32'(out_rd), 8);
    @(negedge clk);

    // hazard against the instruction issuing this cycle
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 32'hC0);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd4, 5'd12, 1'b0, 32'hC1);
    #1;
    check("sch_same", 32'(in_ready), 0);
    @(negedge clk);
    #1;
    check("sch_pend", 32'(in_ready), 0);
    wb_valid = 1'b1;
    wb_rd = 5'd4;
    wb_data = 32'h44;
    wait_accept(n);
    check("sch_lat", 32'(n), 32'(STALL));
    @(negedge clk);
    wb_valid = 1'b0;
    in_valid = 1'b0;
    check("sch_op1", out_op1, 0);
    check("sch_op2", out_op2, 32'h44);
    @(negedge clk);

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 5'd7, 5'd9, 1'b1, 32'hD0);
    #1;
    check("bp_acc", 32'(in_ready), 1);
    @(negedge clk);
    drive(1'b1, 5'd7, 5'd5, 5'd13, 1'b0, 32'hD1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_op1", out_op1, 1);
      check("bp_pl", out_payload, 32'hD0);
      check("bp_rdy", 32'(in_ready), 0);
      check("bp_ren", 32'(rf_r_en), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_nop1", out_op1, 2);
    check("bp_nop2", out_op2, 1);
    check("bp_npl", out_payload, 32'hD1);
    @(negedge clk);

    // x0 source and destination
    drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b1, 32'hE0);
    @(negedge clk);
    check("x0_op1", out_op1, 0);
    check("x0_op2", out_op2, 1);
    check("x0_wen", 32'(out_rd_wen), 1);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'hE1);
    #1;
    check("x0_same", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd14, 1'b0, 32'hE2);
    #1;
    check("x0_later", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    // reset while holding an instruction with x3 pending
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'hF0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 32'hF1);
    @(negedge clk);
    drive(1'b1, 5'd3, 5'd0, 5'd15, 1'b0, 32'hF2);
    #1;
    check("rst_hold", 32'(out_valid), 1);
    check("rst_pre", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_vld", 32'(out_valid), 0);
    check("rst_mid_rd", 32'(out_rd), 0);
    drive(1'b1, 5'd3, 5'd0, 5'd15, 1'b0, 32'hF2);
    #1;
    check("rst_x3", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_x3_vld", 32'(out_valid), 1);
    check("rst_x3_op1", out_op1, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
